// File: rtl/hazard_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : hazard_sequencer
// Brief   : EX-stage forwarding, load-use/branch hazard control and mul/div
//           sequencing for the 5-stage RV32 pipeline.
// Revision: 1.0 - initial release
// ============================================================================
module hazard_sequencer #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic [4:0]       Rs1_E,
    input  logic [4:0]       Rs2_E,
    input  logic [4:0]       RD_E,
    input  logic [4:0]       RD_M,
    input  logic [4:0]       RD_W,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             ResultSrcE,
    input  logic             PCSrcE,
    input  logic             McReqE,
    input  logic             McDoneE,
    output logic [1:0]       ForwardA_E,
    output logic [1:0]       ForwardB_E,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             McStart,
    output logic             McAbort,
    output logic [CNT_W-1:0] StallCount
);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] c_TMO_LAST = 8'(MC_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [7:0]       timer_q, timer_d;
    logic             abort_q, abort_d;
    logic [CNT_W-1:0] cnt_q;
    logic             w_load_use;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       rwm,
        input logic [4:0] rdm,
        input logic       rww,
        input logic [4:0] rdw
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (rwm && (rdm != 5'd0) && (rdm == rs)) begin
            sel = 2'b10;
        end else if (rww && (rdw != 5'd0) && (rdw == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    assign w_load_use = ResultSrcE && (RD_E != 5'd0) &&
                        ((RD_E == Rs1_D) || (RD_E == Rs2_D));

    always_comb begin
        ForwardA_E = 2'b00;
        ForwardB_E = 2'b00;
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        McStart    = 1'b0;
        state_d    = state_q;
        timer_d    = timer_q;
        abort_d    = abort_q;
        if (!rst) begin
            ForwardA_E = fwd_sel(Rs1_E, RegWriteM, RD_M, RegWriteW, RD_W);
            ForwardB_E = fwd_sel(Rs2_E, RegWriteM, RD_M, RegWriteW, RD_W);
            case (state_q)
                RUN: begin
                    if (PCSrcE) begin
                        FlushD = 1'b1;
                        FlushE = 1'b1;
                    end else if (McReqE) begin
                        // Freeze the front end from the launch cycle onward.
                        McStart = 1'b1;
                        StallF  = 1'b1;
                        StallD  = 1'b1;
                        StallE  = 1'b1;
                        state_d = MC_WAIT;
                        timer_d = 8'd0;
                    end else if (w_load_use) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end
                end
                MC_WAIT: begin
                    // Completion wins over a coincident timeout.
                    if (McDoneE) begin
                        state_d = RUN;
                    end else if (timer_q == c_TMO_LAST) begin
                        state_d = RUN;
                        abort_d = 1'b1;
                    end else begin
                        StallF  = 1'b1;
                        StallD  = 1'b1;
                        StallE  = 1'b1;
                        timer_d = timer_q + 8'd1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            timer_q <= 8'd0;
            abort_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            abort_q <= abort_d;
            if (StallF && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign McAbort    = abort_q;
    assign StallCount = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_sequencer
// Brief   : Vector-table and sequence bench for hazard_sequencer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hazard_sequencer;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;
    // Expected control word: {FwdA, FwdB, StallF, StallD, StallE, FlushD, FlushE, McStart}
    localparam logic [9:0] E_LU = 10'b0000110010;
    localparam logic [9:0] E_BR = 10'b0000000110;
    localparam logic [9:0] E_MC = 10'b0000111001;
    localparam logic [9:0] E_ST = 10'b0000111000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] Rs1_D = '0, Rs2_D = '0, Rs1_E = '0, Rs2_E = '0;
    logic [4:0] RD_E = '0, RD_M = '0, RD_W = '0;
    logic RegWriteM = 1'b0, RegWriteW = 1'b0, ResultSrcE = 1'b0;
    logic PCSrcE = 1'b0, McReqE = 1'b0, McDoneE = 1'b0;
    logic [1:0] ForwardA_E, ForwardB_E;
    logic StallF, StallD, StallE, FlushD, FlushE, McStart, McAbort;
    logic [CNT_W-1:0] StallCount;

    always #5 clk = ~clk;

    hazard_sequencer #(.MC_TIMEOUT(8), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
        .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE),
        .PCSrcE(PCSrcE), .McReqE(McReqE), .McDoneE(McDoneE),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .McStart(McStart),
        .McAbort(McAbort), .StallCount(StallCount)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       rwm, rww, rse, pcs, mcreq, mcdone;
        logic [9:0] exp;
    } vec_t;

    vec_t sb_q[$];
    vec_t tbl[14];
    vec_t w;
    int   n_chk = 0;
    int   n_fail = 0;
    int   exp_cnt = 0;
    logic exp_abort = 1'b0;

    function automatic vec_t mkv(string nm, logic [4:0] rs1d, logic [4:0] rs2d,
                                 logic [4:0] rs1e, logic [4:0] rs2e, logic [4:0] rde,
                                 logic [4:0] rdm, logic [4:0] rdw, logic rwm, logic rww,
                                 logic rse, logic pcs, logic mcreq, logic mcdone,
                                 logic [9:0] exp);
        vec_t x;
        x.name = nm;   x.rst = 1'b0;
        x.rs1d = rs1d; x.rs2d = rs2d; x.rs1e = rs1e; x.rs2e = rs2e;
        x.rde = rde;   x.rdm = rdm;   x.rdw = rdw;
        x.rwm = rwm;   x.rww = rww;   x.rse = rse;   x.pcs = pcs;
        x.mcreq = mcreq; x.mcdone = mcdone; x.exp = exp;
        return x;
    endfunction

    function automatic vec_t idle(string nm);
        return mkv(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'd0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", nm, act, exp);
        end
    endtask

    task automatic step(input vec_t x);
        vec_t e;
        rst = x.rst;
        Rs1_D = x.rs1d; Rs2_D = x.rs2d; Rs1_E = x.rs1e; Rs2_E = x.rs2e;
        RD_E = x.rde;   RD_M = x.rdm;   RD_W = x.rdw;
        RegWriteM = x.rwm; RegWriteW = x.rww; ResultSrcE = x.rse;
        PCSrcE = x.pcs; McReqE = x.mcreq; McDoneE = x.mcdone;
        sb_q.push_back(x);
        @(negedge clk);
        e = sb_q.pop_front();
        chk({e.name, "/ctl"},
            {22'd0, ForwardA_E, ForwardB_E, StallF, StallD, StallE, FlushD, FlushE, McStart},
            {22'd0, e.exp});
        if (e.rst) begin
            exp_cnt   = 0;
            exp_abort = 1'b0;
        end else if (e.exp[5] && exp_cnt < CNT_MAX) begin
            exp_cnt++;
        end
        @(posedge clk);
        #1;
        chk({e.name, "/cnt"}, 32'(StallCount), 32'(exp_cnt));
        chk({e.name, "/abort"}, {31'd0, McAbort}, {31'd0, exp_abort});
    endtask

    // Launches an op and holds it for n stalled MC_WAIT cycles.
    task automatic mc_launch(input string nm, input int n);
        w = idle({nm, "_entry"}); w.mcreq = 1'b1; w.exp = E_MC; step(w);
        for (int i = 0; i < n; i++) begin
            w = idle({nm, "_wait"}); w.mcreq = 1'b1; w.exp = E_ST; step(w);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0]  = mkv("fwdA_mem",    0, 0, 5, 0, 0, 5, 5, 1, 1, 0, 0, 0, 0, 10'b1000000000);
        tbl[1]  = mkv("fwdA_wb",     0, 0, 5, 0, 0, 5, 5, 0, 1, 0, 0, 0, 0, 10'b0100000000);
        tbl[2]  = mkv("fwdA_x0",     0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 10'b0000000000);
        tbl[3]  = mkv("fwdB_mem",    0, 0, 3, 9, 0, 9, 9, 1, 1, 0, 0, 0, 0, 10'b0010000000);
        tbl[4]  = mkv("fwdAB_mix",   0, 0, 4, 6, 0, 4, 6, 1, 1, 0, 0, 0, 0, 10'b1001000000);
        tbl[5]  = mkv("fwdB_wb",     0, 0, 0, 6, 0, 2, 6, 1, 1, 0, 0, 0, 0, 10'b0001000000);
        tbl[6]  = mkv("lu_rs2",      0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 0, 0, 0, E_LU);
        tbl[7]  = mkv("lu_once",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'b0000000000);
        tbl[8]  = mkv("lu_rs1",     12, 0, 0, 0,12, 0, 0, 0, 0, 1, 0, 0, 0, E_LU);
        tbl[9]  = mkv("lu_rd0",      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 10'b0000000000);
        tbl[10] = mkv("nonload",     0, 7, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 10'b0000000000);
        tbl[11] = mkv("br_lu",       0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 1, 0, 0, E_BR);
        tbl[12] = mkv("br_mcreq",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, E_BR);
        tbl[13] = mkv("done_in_run", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10'b0000000000);

        repeat (2) @(posedge clk);
        #1;
        w = mkv("rst_forced", 0, 7, 5, 0, 7, 5, 0, 1, 0, 1, 0, 1, 0, 10'd0);
        w.rst = 1'b1;
        step(w);

        foreach (tbl[i]) step(tbl[i]);

        // mul/div completing after three wait cycles; hazards ignored meanwhile
        w = idle("mc_entry"); w.mcreq = 1'b1; w.exp = E_MC; step(w);
        w = idle("mc_wait1"); w.mcreq = 1'b1; w.exp = E_ST; step(w);
        w = mkv("mc_wait_hz", 0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 1, 1, 0, E_ST); step(w);
        w = mkv("mc_wait_fw", 0, 0, 5, 0, 0, 5, 0, 1, 0, 0, 0, 1, 0, E_ST | 10'b1000000000);
        step(w);
        w = idle("mc_done"); w.mcreq = 1'b1; w.mcdone = 1'b1; step(w);
        w = mkv("mc_back_run", 0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 0, 0, 0, E_LU); step(w);

        // done arriving on the timeout cycle is a completion
        mc_launch("dto", 7);
        w = idle("dto_done"); w.mcreq = 1'b1; w.mcdone = 1'b1; step(w);
        w = idle("dto_run"); step(w);

        // genuine timeout: abort sets and stays set
        mc_launch("tmo", 7);
        exp_abort = 1'b1;
        w = idle("tmo_release"); w.mcreq = 1'b1; step(w);
        for (int i = 0; i < 3; i++) begin
            w = idle("tmo_sticky"); step(w);
        end
        w = idle("tmo_done_run"); w.mcdone = 1'b1; step(w);

        // reset on the third MC_WAIT cycle
        mc_launch("rmid", 2);
        w = mkv("rmid_rst", 0, 0, 5, 5, 0, 5, 5, 1, 1, 0, 0, 1, 0, 10'd0);
        w.rst = 1'b1;
        step(w);
        w = idle("rmid_idle"); step(w);
        w = idle("rmid_late_done"); w.mcdone = 1'b1; step(w);
        w = mkv("rmid_run", 0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 0, 0, 0, E_LU); step(w);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
